// File: rtl/osd_spi_tx.sv
// SPI master for the OSD command link: sends enable/disable and line-write commands with pixel payload.
// Optional OSD_SPI_TX_FILL_EN adds cmd_fill/fill_byte so a write line can be sent with one repeated byte.
module osd_spi_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [2:0] cmd_arg,
  input  logic [8:0] cmd_len,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       busy,
  output logic       sck,
  output logic       ss,
  output logic       sdi
`ifdef OSD_SPI_TX_FILL_EN
  ,
  input  logic       cmd_fill,
  input  logic [7:0] fill_byte
`endif
);

  localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_TAIL,
    S_GAP
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [8:0] div_cnt;
  logic [8:0] rem;

  logic       accept;
  logic [7:0] cmd_byte;
  logic [8:0] len_next;
  logic [7:0] load_byte;
  logic       fill_q;
  logic [7:0] fill_byte_q;

  assign accept = cmd_valid && cmd_ready;
  assign busy   = !cmd_ready;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    cmd_byte = {5'b01000, 2'b00, cmd_arg[0]};
    len_next = 9'd0;
    if (cmd_op) begin
      cmd_byte = {5'b00100, cmd_arg};
      len_next = (cmd_len > 9'd256) ? 9'd256 : cmd_len;
    end
  end

`ifdef OSD_SPI_TX_FILL_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= 1'b0;
      fill_byte_q <= 8'h00;
    end else if (accept) begin
      fill_q      <= cmd_fill && cmd_op;
      fill_byte_q <= fill_byte;
    end
  end
`else
  assign fill_q      = 1'b0;
  assign fill_byte_q = 8'h00;
`endif

  assign load_byte = fill_q ? fill_byte_q : data;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      data_ready <= 1'b0;
      sck        <= 1'b0;
      ss         <= 1'b1;
      sdi        <= 1'b0;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      div_cnt    <= 9'd0;
      rem        <= 9'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            ss        <= 1'b0;
            sck       <= 1'b0;
            sdi       <= cmd_byte[7];
            shreg     <= cmd_byte;
            rem       <= len_next;
            bit_cnt   <= 3'd0;
            div_cnt   <= 9'd0;
            state     <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 9'd0;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              sck <= 1'b0;
              if (bit_cnt == 3'd7) begin
                // sdi holds bit0 across LOAD so a stalled link shows no data change.
                bit_cnt <= 3'd0;
                if (rem != 9'd0) begin
                  data_ready <= !fill_q;
                  state      <= S_LOAD;
                end else begin
                  state <= S_TAIL;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], 1'b0};
                sdi     <= shreg[6];
              end
            end
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        S_LOAD: begin
          if (fill_q || (data_ready && data_valid)) begin
            data_ready <= 1'b0;
            shreg      <= load_byte;
            sdi        <= load_byte[7];
            rem        <= rem - 9'd1;
            div_cnt    <= 9'd0;
            state      <= S_SHIFT;
          end
        end

        S_TAIL: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 9'd0;
            ss      <= 1'b1;
            state   <= S_GAP;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        S_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt   <= 9'd0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          ss        <= 1'b1;
          sck       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_spi_tx.sv
// Self-checking bench for osd_spi_tx: an SPI slave model decodes bytes and pops them from an expected queue.
module tb_osd_spi_tx;
  localparam int D = 2;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [2:0] cmd_arg = 3'd0;
  logic [8:0] cmd_len = 9'd0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       cmd_ready, data_ready, busy, sck, ss, sdi;
`ifdef OSD_SPI_TX_FILL_EN
  logic       cmd_fill = 1'b0;
  logic [7:0] fill_byte = 8'h00;
`endif

  osd_spi_tx #(.CLK_DIV(D)) dut (
    .pclk(pclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_len(cmd_len), .data(data),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .sck(sck), .ss(ss), .sdi(sdi)
`ifdef OSD_SPI_TX_FILL_EN
    , .cmd_fill(cmd_fill), .fill_byte(fill_byte)
`endif
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] stim[$];
  logic [7:0] rx_sh = 8'h00;
  int         rx_bits = 0;
  int         rises = 0;
  int         hs_cnt = 0;
  int         dr_cycles = 0;
  int         stall_cnt = 0;
  int         stall_left = -1;
  bit         pend = 1'b0;
  logic       sck_d = 1'b0, ss_d = 1'b1, sdi_d = 1'b0;
  int         base_rises, base_hs, base_dr;

  // Slave model, protocol watch and payload driver share one process so their ordering is fixed.
  always @(negedge pclk) begin
    if (!rst_n) begin
      rx_bits    = 0;
      pend       = 1'b0;
      data_valid = 1'b0;
      sck_d      = 1'b0;
      ss_d       = 1'b1;
      sdi_d      = 1'b0;
    end else begin
      if (sck && !sck_d) begin
        rises++;
        check("ss_low_at_rise", ss, 0);
        rx_sh = {rx_sh[6:0], sdi};
        rx_bits++;
        if (rx_bits == 8) begin
          rx_bits = 0;
          if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
          else                   check("rx_byte", rx_sh, exp_q.pop_front());
        end
      end
      if (ss && !ss_d) rx_bits = 0;
      if (ss !== ss_d) check("sck_low_at_ss_edge", sck, 0);
      if (data_ready && !data_valid) begin
        check("stall_sck", sck, 0);
        check("stall_ss", ss, 0);
        check("stall_sdi_hold", sdi, sdi_d);
      end
      if (data_ready) dr_cycles++;

      if (pend) begin
        void'(pay.pop_front());
        pend = 1'b0;
      end
      if (pay.size() > 0 && stall_cnt > 0 && pay.size() == stall_left) begin
        data_valid = 1'b0;
        if (data_ready) stall_cnt--;
      end else begin
        data_valid = (pay.size() > 0);
      end
      data = (pay.size() > 0) ? pay[0] : 8'h00;
      if (data_ready && data_valid) begin
        pend = 1'b1;
        hs_cnt++;
      end
      sck_d = sck;
      ss_d  = ss;
      sdi_d = sdi;
    end
  end

  task automatic start_cmd(input logic op, input logic [2:0] arg, input int len,
                           input logic fill, input logic [7:0] fb);
    logic [7:0] cb;
    logic [7:0] b;
    int         n;
    cb = op ? {5'b00100, arg} : {5'b01000, 2'b00, arg[0]};
    n  = op ? ((len > 256) ? 256 : len) : 0;
    exp_q.push_back(cb);
    for (int i = 0; i < n; i++) begin
      b = fill ? fb : stim[i];
      exp_q.push_back(b);
      if (!fill) pay.push_back(b);
    end
    for (int i = 0; i < 1000 && !cmd_ready; i++) @(negedge pclk);
    check("ready_before_cmd", cmd_ready, 1);
    base_rises = rises;
    base_hs    = hs_cnt;
    base_dr    = dr_cycles;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_arg    = arg;
    cmd_len    = 9'(len);
`ifdef OSD_SPI_TX_FILL_EN
    cmd_fill   = fill;
    fill_byte  = fb;
`endif
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_arg   = ~arg;
    cmd_len   = 9'h1AB;
    cmd_op    = ~op;
    check("start_ss", ss, 0);
    check("start_sck", sck, 0);
    check("start_sdi", sdi, cb[7]);
    check("start_busy", busy, 1);
  endtask

  task automatic finish_cmd(input string tag, input int exp_lat, input int nbytes, input int nhs);
    int lat;
    int gap;
    lat = 1;
    gap = 0;
    while (!cmd_ready && lat < 20000) begin
      @(negedge pclk);
      lat++;
      if (ss && !cmd_ready) gap++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_gap"}, gap, 2 * D);
    check({tag, "_rises"}, rises - base_rises, 8 * nbytes);
    check({tag, "_handshakes"}, hs_cnt - base_hs, nhs);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_busy_end"}, busy, 0);
    if (nhs == 0) check({tag, "_ready_never"}, dr_cycles - base_dr, 0);
  endtask

  function automatic int lat_of(input int len, input int stall);
    return 1 + 16 * D * (1 + len) + len + 3 * D + stall;
  endfunction

  initial begin
    repeat (3) @(negedge pclk);
    check("rst_ss", ss, 1);
    check("rst_sck", sck, 0);
    check("rst_sdi", sdi, 0);
    check("rst_data_ready", data_ready, 0);
    #1 rst_n = 1'b1;
    @(negedge pclk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);

    start_cmd(1'b0, 3'd1, 0, 1'b0, 8'h00);
    finish_cmd("ctl_on", lat_of(0, 0), 1, 0);

    stim = '{8'hA5, 8'h3C, 8'hFF};
    start_cmd(1'b1, 3'd5, 3, 1'b0, 8'h00);
    finish_cmd("wr5", lat_of(3, 0), 4, 3);

    stall_cnt  = 20;
    stall_left = 2;
    start_cmd(1'b1, 3'd5, 3, 1'b0, 8'h00);
    finish_cmd("wr5_stall", lat_of(3, 20), 4, 3);
    check("stall_consumed", stall_cnt, 0);
    stall_left = -1;

    start_cmd(1'b1, 3'd7, 0, 1'b0, 8'h00);
    finish_cmd("wr7_len0", lat_of(0, 0), 1, 0);

    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'(i * 7 + 3));
    start_cmd(1'b1, 3'd3, 300, 1'b0, 8'h00);
    finish_cmd("wr_clamp", lat_of(256, 0), 257, 256);

    stim = '{8'hC3, 8'h96, 8'hE1};
    start_cmd(1'b1, 3'd2, 3, 1'b0, 8'h00);
    for (int i = 0; i < 2000 && (rises - base_rises) < 12; i++) @(negedge pclk);
    check("rst_reach_bit3", (rises - base_rises) >= 12, 1);
    repeat (2) @(negedge pclk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ss", ss, 1);
    check("midrst_sck", sck, 0);
    check("midrst_sdi", sdi, 0);
    check("midrst_data_ready", data_ready, 0);
    exp_q.delete();
    pay.delete();
    repeat (2) @(negedge pclk);
    #1 rst_n = 1'b1;
    @(negedge pclk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    start_cmd(1'b0, 3'd0, 0, 1'b0, 8'h00);
    finish_cmd("ctl_off_after_rst", lat_of(0, 0), 1, 0);

`ifdef OSD_SPI_TX_FILL_EN
    start_cmd(1'b1, 3'd0, 256, 1'b1, 8'h00);
    finish_cmd("fill256", lat_of(256, 0), 257, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got no_finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/osd_spi_tx.md
# osd_spi_tx

SPI master that drives the OSD command link: serialises OSD enable/disable commands and line-write commands with their pixel payload onto `sck`/`ss`/`sdi`. The host side is a command handshake plus a byte-stream handshake. It sits in a core's control path, in place of an external IO controller, when the core generates its own menu overlay, and feeds the OSD overlay block's SPI slave port directly.

## Interface
- `CLK_DIV`, default 2: `pclk` cycles per `sck` half-period; legal range 1..255.
- `pclk` input 1: sole clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: block idle, can accept a command.
- `cmd_op` input 1: 0 = enable control, 1 = line write.
- `cmd_arg` input 3: line number for a write; bit0 = enable value for control.
- `cmd_len` input 9: payload byte count for a write, 0..256; ignored for control.
- `data` input 8: payload byte.
- `data_valid` input 1: payload byte available.
- `data_ready` output 1: block is taking a payload byte this cycle.
- `busy` output 1: transaction in progress; equals `!cmd_ready`.
- `sck` output 1: SPI clock, idles low; slave samples on the rising edge.
- `ss` output 1: active-low select, idles high.
- `sdi` output 1: serial data, MSB first.

## Operation
- Command byte: control = `{5'b01000, 2'b00, cmd_arg[0]}` (0x40/0x41); write = `{5'b00100, cmd_arg[2:0]}` (0x20..0x27).
- Accept on `cmd_valid && cmd_ready`. Latch op, command byte, and remaining count (= `cmd_len` for a write, 0 for control). Inputs are don't-care afterwards.
- FSM states:
  - IDLE: `cmd_ready=1`, `ss=1`.
  - SHIFT: 8 bits, with `sck` toggling every `CLK_DIV` cycles.
  - LOAD: remaining count ≠ 0. Assert `data_ready` until `data_valid`, take the byte, decrement the count, go to SHIFT.
  - TAIL: `ss` low, `sck` low for `CLK_DIV` cycles.
  - GAP: `ss` high for `2*CLK_DIV` cycles, then IDLE.
- After the 8th falling edge of a byte: go to LOAD if the count ≠ 0, else TAIL.
- Stall: while in LOAD with `data_valid=0`, hold `sck=0`, `ss=0`, and `sdi` at its last value. No edges are generated. The slave is edge-driven, so stalls are harmless.
- Count arithmetic is 9-bit unsigned. `cmd_len=256` sends 256 bytes. `cmd_len=0` sends the command byte only. Values above 256 are clamped to 256.
- `data_ready` is registered and only asserts in LOAD. At most one byte is taken per handshake; the byte is latched in the handshake cycle.
- Reset (asserted asynchronously, including mid-transaction): `ss=1`, `sck=0`, `sdi=0`, `data_ready=0`. The FSM goes to IDLE and the counters clear. After release: `cmd_ready=1`, `busy=0`. The slave discards any partial command because `ss` went high.

## Timing
- Accept cycle N. At N+1: `ss=0`, `sdi`=command bit7, `sck=0`.
- Each bit: `sdi` is stable for `CLK_DIV` cycles with `sck` low, then `sck` is high for `CLK_DIV` cycles. `sdi` changes only in the cycle `sck` falls, or when a new byte is loaded.
- One unstalled byte = `16*CLK_DIV` cycles.
- LOAD costs 1 cycle when `data_valid` is already high. That byte's bit7 appears on `sdi` the next cycle.
- Control transaction with `CLK_DIV=2`: 32 (shift) + 2 (TAIL) + 4 (GAP) cycles. `cmd_ready` rises 39 cycles after the accept cycle.
- `sck` never rises while `ss=1`. `ss` never changes while `sck=1`.

## Configuration
- `OSD_SPI_TX_FILL_EN`:
  - Defined: adds input `cmd_fill` (1) and `fill_byte` (8), both latched at accept. For a write with `cmd_fill=1`, every payload byte is `fill_byte`, LOAD takes 1 cycle, and `data_ready` stays 0.
  - Undefined: ports absent; every payload byte comes from `data`.

## Test plan
- `CLK_DIV=2`, control `cmd_arg=1`: 8 `sck` rises sampling 0x41, `ss` low throughout, `ss` high ≥4 cycles before `cmd_ready=1`.
- Write line 5, `cmd_len=3`, bytes A5/3C/FF always valid: 32 rises decoding 0x25,0xA5,0x3C,0xFF; exactly 3 `data_ready` handshakes.
- Same write with `data_valid` low for 20 cycles before the 2nd byte: `sck` held low and `ss` low during the stall, no extra edges, identical decoded bytes.
- Write line 7, `cmd_len=0`: only 0x27 sent; `data_ready` never asserts.
- Assert `rst_n=0` during bit 3 of a payload byte: `ss=1` and `sck=0` in the same cycle; `cmd_ready=1` after release; a following control command decodes correctly.
- With `OSD_SPI_TX_FILL_EN`, write line 0, `cmd_len=256`, fill 0x00: 2056 `sck` rises, bytes 0x20 then 256×0x00, `data_ready` never high.
